// File: rtl/snake_dir_tick.sv
// snake_dir_tick: button edge detection, reversal-safe direction queue and
// speed-levelled game tick generator with pause. Queued directions are applied
// only on game ticks, so quick presses between ticks are honoured in order.
module snake_dir_tick #(
    parameter int TICK_BASE = 25000000,
    parameter int TICK_STEP = 2000000,
    parameter int TICK_MIN  = 5000000,
    parameter int LEVEL_W   = 4,
    parameter int QDEPTH    = 2,
    parameter int CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                dir_in,
    input  logic                      speed_up,
    input  logic                      pause,
    output logic                      tick,
    output logic [1:0]                dir_out,
    output logic [LEVEL_W-1:0]        level,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      drop
);

    localparam int PW = CNT_W + LEVEL_W + 1;
    localparam int P0 = (TICK_BASE > TICK_MIN) ? TICK_BASE : TICK_MIN;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    logic [3:0]        prev_btn;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        q_mem [QDEPTH];

    logic [3:0]        press;
    logic              cand_valid;
    logic [1:0]        cand;
    logic [1:0]        ref_dir;
    logic              same_dir;
    logic              opposite;
    logic              full;
    logic              reject;
    logic              tick_now;
    logic              pop;
    logic              push;
    int                wr_idx;
    logic [PW-1:0]     prod;
    logic signed [PW-1:0] diff;
    logic [CNT_W-1:0]  reload;

    // Falling-edge press detection with fixed priority up > down > left > right.
    always_comb begin
        press      = prev_btn & ~dir_in;
        cand_valid = |press;
        if (press[3])      cand = 2'b00;
        else if (press[2]) cand = 2'b01;
        else if (press[1]) cand = 2'b10;
        else               cand = 2'b11;
    end

    // Enqueue decision against the pre-pop tail (or applied direction if empty).
    always_comb begin
        ref_dir = dir_out;
        for (int i = 0; i < QDEPTH; i++) begin
            if (int'(q_count) == i + 1) ref_dir = q_mem[i];
        end
        same_dir = (cand == ref_dir);
        opposite = (cand[1] == ref_dir[1]) && (cand[0] != ref_dir[0]);
        full     = (int'(q_count) == QDEPTH);
        tick_now = !reset && !pause && (cnt == '0);
        pop      = tick_now && (q_count != '0);
        reject   = same_dir || opposite || (full && !pop);
        push     = !reset && cand_valid && !reject;
        drop     = !reset && cand_valid && reject;
        tick     = tick_now;
        wr_idx   = int'(q_count) - (pop ? 1 : 0);
    end

    // Reload value for the current level; negative differences clamp to TICK_MIN.
    always_comb begin
        prod = PW'(level) * PW'(TICK_STEP);
        diff = $signed(PW'(TICK_BASE)) - $signed(prod);
        if (diff < $signed(PW'(TICK_MIN))) reload = CNT_W'(TICK_MIN - 1);
        else                               reload = CNT_W'(diff - PW'(1));
    end

    // Button history and tick down-counter (held while paused).
    always_ff @(posedge clk) begin
        prev_btn <= dir_in;
        if (reset) begin
            cnt <= CNT_W'(P0 - 1);
        end else if (!pause) begin
            if (cnt == '0) cnt <= reload;
            else           cnt <= cnt - 1'b1;
        end
    end

    // Saturating speed level; only affects the next reload.
    always_ff @(posedge clk) begin
        if (reset)                             level <= '0;
        else if (speed_up && level != LEVEL_MAX) level <= level + 1'b1;
    end

    // Direction queue: head shifts out into dir_out on a tick, push writes the tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_count <= '0;
            dir_out <= 2'b11;
            for (int i = 0; i < QDEPTH; i++) q_mem[i] <= 2'b00;
        end else begin
            if (pop) begin
                dir_out <= q_mem[0];
                for (int i = 0; i < QDEPTH - 1; i++) q_mem[i] <= q_mem[i+1];
            end
            for (int i = 0; i < QDEPTH; i++) begin
                if (push && i == wr_idx) q_mem[i] <= cand;
            end
            if (push && !pop)      q_count <= q_count + 1'b1;
            else if (pop && !push) q_count <= q_count - 1'b1;
        end
    end

endmodule
